// File: rtl/alu_sequencer.sv
// Serialized execute/writeback controller wrapped around a 32x32 register file.
// Each command walks IDLE -> READ -> EXEC -> WB, so no forwarding is needed.
module alu_sequencer #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rs1,
  input  logic [AW-1:0]    cmd_rs2,
  input  logic [AW-1:0]    cmd_rd,
  output logic             rf_enable,
  output logic             rf_read,
  output logic [AW-1:0]    rf_o1_addr,
  output logic [AW-1:0]    rf_o2_addr,
  input  logic [WIDTH-1:0] rf_o1,
  input  logic [WIDTH-1:0] rf_o2,
  output logic             rf_write,
  output logic [AW-1:0]    rf_in_addr,
  output logic [WIDTH-1:0] rf_in,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_t            state_reg;
  logic              ready_reg;
  logic [2:0]        op_reg;
  logic [AW-1:0]     rd_reg;
  logic [WIDTH-1:0]  sum;
  logic [WIDTH-1:0]  diff;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_ovf;

  // Gated by reset so the block never advertises readiness while held in reset.
  assign cmd_ready = ready_reg & reset;

  assign sum  = rf_o1 + rf_o2;
  assign diff = rf_o1 - rf_o2;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_reg)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (rf_o1[WIDTH-1] == rf_o2[WIDTH-1]) && (sum[WIDTH-1] != rf_o1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (rf_o1[WIDTH-1] != rf_o2[WIDTH-1]) && (diff[WIDTH-1] != rf_o1[WIDTH-1]);
      end
      OP_AND:  alu_res = rf_o1 & rf_o2;
      OP_OR:   alu_res = rf_o1 | rf_o2;
      OP_XOR:  alu_res = rf_o1 ^ rf_o2;
      OP_SLL:  alu_res = rf_o1 << rf_o2[4:0];
      OP_SRL:  alu_res = rf_o1 >> rf_o2[4:0];
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(rf_o1) < $signed(rf_o2))};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      ready_reg  <= 1'b0;
      op_reg     <= '0;
      rd_reg     <= '0;
      rf_enable  <= 1'b0;
      rf_read    <= 1'b0;
      rf_o1_addr <= '0;
      rf_o2_addr <= '0;
      rf_write   <= 1'b0;
      rf_in_addr <= '0;
      rf_in      <= '0;
      done       <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b1;
          if (cmd_valid && ready_reg) begin
            ready_reg  <= 1'b0;
            op_reg     <= cmd_op;
            rd_reg     <= cmd_rd;
            rf_o1_addr <= cmd_rs1;
            rf_o2_addr <= cmd_rs2;
            rf_enable  <= 1'b1;
            rf_read    <= 1'b1;
            state_reg  <= READ;
          end
        end
        READ: begin
          rf_enable <= 1'b0;
          rf_read   <= 1'b0;
          state_reg <= EXEC;
        end
        EXEC: begin
          result     <= alu_res;
          zero       <= (alu_res == '0);
          ovf        <= alu_ovf;
          rf_in      <= alu_res;
          rf_in_addr <= rd_reg;
          // r0 is a discard destination: retire without touching the file.
          rf_write   <= (rd_reg != '0);
          rf_enable  <= (rd_reg != '0);
          done       <= 1'b1;
          state_reg  <= WB;
        end
        WB: begin
          rf_write  <= 1'b0;
          rf_enable <= 1'b0;
          done      <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural register file, reference ALU model and
// a scoreboard queue drained by a monitor that watches done.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [4:0]  cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
  logic        rf_enable, rf_read, rf_write, done, zero, ovf;
  logic [4:0]  rf_o1_addr, rf_o2_addr, rf_in_addr;
  logic [31:0] rf_o1 = '0, rf_o2 = '0, rf_in, result;

  logic        pre_we = 1'b0;
  logic [4:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] mem [32] = '{default: 32'd0};
  logic [31:0] ref_regs [32] = '{default: 32'd0};

  int cyc = 0;
  int passed = 0;
  int total = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        v;
    logic [4:0]  rd;
    int          acc;
  } exp_t;
  exp_t q[$];

  alu_sequencer #(.WIDTH(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .rf_enable(rf_enable), .rf_read(rf_read),
    .rf_o1_addr(rf_o1_addr), .rf_o2_addr(rf_o2_addr),
    .rf_o1(rf_o1), .rf_o2(rf_o2),
    .rf_write(rf_write), .rf_in_addr(rf_in_addr), .rf_in(rf_in),
    .done(done), .result(result), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file with registered read outputs, plus a bench-side preload port.
  always @(posedge clk) begin
    if (rf_enable && rf_read) begin
      rf_o1 <= mem[rf_o1_addr];
      rf_o2 <= mem[rf_o2_addr];
    end
    if (rf_write) mem[rf_in_addr] <= rf_in;
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic z, output logic v);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v = 1'b0;
    case (op)
      3'd0: begin s = sa + sb; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd1: begin s = sa - sb; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: r = a >> b[4:0];
      default: r = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    z = (r == 32'd0);
  endfunction

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    ref_regs[a] = d;
  endtask

  // Offers one command; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit push, output int acc);
    logic [31:0] r;
    logic z, v;
    bit got;
    got = 0;
    acc = -1;
    cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_valid = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      if (cmd_ready) begin got = 1; acc = cyc; end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!got) begin
      total++;
      $display("FAIL accept_timeout: op %0d never accepted", op);
    end else if (push) begin
      model(op, ref_regs[rs1], ref_regs[rs2], r, z, v);
      if (rd != 5'd0) ref_regs[rd] = r;
      q.push_back('{res: r, z: z, v: v, rd: rd, acc: acc});
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 60; n++) begin
      if (q.size() == 0 && cmd_ready) break;
      @(negedge clk);
    end
    chk("drain", {31'd0, (q.size() == 0 && cmd_ready)}, 32'd1);
  endtask

  // Monitor: every retirement is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && done) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: result %h with no command pending", result);
      end else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("zero", {31'd0, zero}, {31'd0, e.z});
        chk("ovf", {31'd0, ovf}, {31'd0, e.v});
        chk("rf_write", {31'd0, rf_write}, {31'd0, (e.rd != 5'd0)});
        chk("done_cycle", cyc, e.acc + 3);
        if (e.rd != 5'd0) begin
          chk("rf_in_addr", {27'd0, rf_in_addr}, {27'd0, e.rd});
          chk("rf_in", rf_in, e.res);
        end
      end
    end
    if (rf_write && !done) begin
      total++;
      $display("FAIL stray_write: rf_write=1 addr %0d without done", rf_in_addr);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, acc;
    logic [4:0] rr;

    // Reset behaviour.
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_strobes", {29'd0, rf_enable, rf_read, rf_write}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    preload(5'd1, 32'd111111);
    preload(5'd2, 32'd9999999);
    preload(5'd4, 32'h8000_0000);
    preload(5'd5, 32'd1);
    preload(5'd10, 32'h7FFF_FFFF);
    preload(5'd6, 32'hFFFF_FFFF);
    preload(5'd7, 32'd1);
    preload(5'd11, 32'd31);
    preload(5'd12, 32'd1);
    preload(5'd20, 32'h0000_1234);

    // Directed arithmetic cases.
    issue(3'd0, 5'd1, 5'd2, 5'd3, 1, acc);
    wait_idle();
    chk("r3_sum", mem[3], 32'd10111110);
    issue(3'd1, 5'd4, 5'd5, 5'd13, 1, acc);
    issue(3'd0, 5'd10, 5'd5, 5'd14, 1, acc);
    issue(3'd1, 5'd1, 5'd1, 5'd15, 1, acc);
    issue(3'd7, 5'd6, 5'd7, 5'd16, 1, acc);
    issue(3'd6, 5'd4, 5'd11, 5'd17, 1, acc);
    issue(3'd5, 5'd12, 5'd11, 5'd18, 1, acc);
    wait_idle();
    chk("r13_sub", mem[13], 32'h7FFF_FFFF);
    chk("r16_slt", mem[16], 32'd1);
    chk("r18_sll", mem[18], 32'h8000_0000);

    // Back-to-back with a dependent chain.
    issue(3'd0, 5'd1, 5'd2, 5'd8, 1, a0);
    issue(3'd0, 5'd8, 5'd8, 5'd9, 1, a1);
    issue(3'd4, 5'd9, 5'd1, 5'd19, 1, a2);
    chk("b2b_gap1", a1 - a0, 32'd4);
    chk("b2b_gap2", a2 - a1, 32'd4);
    wait_idle();
    chk("r9_chain", mem[9], 32'd20222220);

    // Discard destination.
    issue(3'd0, 5'd1, 5'd2, 5'd0, 1, acc);
    wait_idle();
    chk("r0_unchanged", mem[0], 32'd0);

    // Reset during EXEC aborts the command.
    issue(3'd0, 5'd1, 5'd2, 5'd20, 0, acc);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_quiet", {30'd0, done, rf_write}, 32'd0);
      chk("abort_ready", {31'd0, cmd_ready}, 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", {31'd0, cmd_ready}, 32'd1);
    chk("r20_untouched", mem[20], 32'h0000_1234);
    issue(3'd3, 5'd1, 5'd20, 5'd21, 1, acc);
    wait_idle();

    // Randomized commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        rr = 5'(20 + $urandom_range(0, 11));
        preload(rr, $urandom);
      end
      issue(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 1, acc);
    end
    wait_idle();
    for (int r = 0; r < 32; r++) chk($sformatf("final_r%0d", r), mem[r], ref_regs[r]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
